// File: rtl/sgmii_pcs_tx_if.sv
// GMII-side inputs and encoder-side outputs of the SGMII transmit PCS.
// The master drives GMII plus the encoder disparity feedback; the PCS is the slave.
interface sgmii_pcs_tx_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_err;
    logic       tx_disp;
    logic [7:0] tx_byte;
    logic       tx_is_k;
    logic       tx_even;
    logic       tx_in_frame;

    modport master (
        output gmii_txd, gmii_tx_en, gmii_tx_err, tx_disp,
        input  tx_byte, tx_is_k, tx_even, tx_in_frame
    );

    modport slave (
        input  gmii_txd, gmii_tx_en, gmii_tx_err, tx_disp,
        output tx_byte, tx_is_k, tx_even, tx_in_frame
    );
endinterface

// File: rtl/sgmii_pcs_tx.sv
// SGMII transmit PCS ordered-set generator: turns GMII tx into a byte + K-flag stream
// carrying /I/ idles, /S/ /T/ /R/ /V/ framing and /C/ autoneg configuration sets.
module sgmii_pcs_tx #(
    parameter bit VOID_ON_ERR  = 1'b1,
    parameter int CFG_MIN_SETS = 1
) (
    input  logic          clk_125mhz,
    input  logic          rst_n,
    sgmii_pcs_tx_if.slave pcs,
    input  logic          xmit_config,
    input  logic [15:0]   config_tx
);
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] K_S   = 8'hFB;
    localparam logic [7:0] K_T   = 8'hFD;
    localparam logic [7:0] K_R   = 8'hF7;
    localparam logic [7:0] K_V   = 8'hFE;
    localparam logic [3:0] MIN_PAIRS = 4'(CFG_MIN_SETS);
    localparam logic [3:0] PAIR_MAX  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DATA, ST_EOP_T, ST_EOP_R, ST_EOP_R2, ST_CONFIG
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  byte_reg, byte_next;
    logic        is_k_reg, is_k_next;
    logic        even_reg;
    logic        in_frame_reg, in_frame_next;
    logic [2:0]  cfg_pos_reg, cfg_pos_next, cfg_pos_inc;
    logic [15:0] cfg_word_reg, cfg_word_next;
    logic [3:0]  pair_cnt_reg, pair_cnt_next, pair_cnt_done;
    logic        next_even;

    assign next_even   = ~even_reg;
    assign cfg_pos_inc = cfg_pos_reg + 3'd1;
    // Leaving byte 7 of the C1+C2 cycle closes one complete pair.
    assign pair_cnt_done = (cfg_pos_reg == 3'd7 && pair_cnt_reg != PAIR_MAX)
                         ? pair_cnt_reg + 4'd1 : pair_cnt_reg;

    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            byte_reg     <= K28_5;
            is_k_reg     <= 1'b1;
            even_reg     <= 1'b1;
            in_frame_reg <= 1'b0;
            cfg_pos_reg  <= 3'd0;
            cfg_word_reg <= 16'h0000;
            pair_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            byte_reg     <= byte_next;
            is_k_reg     <= is_k_next;
            even_reg     <= ~even_reg;
            in_frame_reg <= in_frame_next;
            cfg_pos_reg  <= cfg_pos_next;
            cfg_word_reg <= cfg_word_next;
            pair_cnt_reg <= pair_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_next     = K28_5;
        is_k_next     = 1'b1;
        in_frame_next = 1'b0;
        cfg_pos_next  = cfg_pos_reg;
        cfg_word_next = cfg_word_reg;
        pair_cnt_next = pair_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!next_even) begin
                    // /I1/ flips a positive running disparity back, /I2/ preserves it.
                    byte_next = pcs.tx_disp ? D5_6 : D16_2;
                    is_k_next = 1'b0;
                end else if (xmit_config) begin
                    state_next    = ST_CONFIG;
                    cfg_pos_next  = 3'd0;
                    cfg_word_next = config_tx;
                    pair_cnt_next = 4'd0;
                end else if (pcs.gmii_tx_en) begin
                    state_next    = ST_DATA;
                    byte_next     = K_S;
                    in_frame_next = 1'b1;
                end
            end
            ST_DATA: begin
                in_frame_next = 1'b1;
                if (!pcs.gmii_tx_en) begin
                    state_next = ST_EOP_T;
                    byte_next  = K_T;
                end else if (pcs.gmii_tx_err && VOID_ON_ERR) begin
                    byte_next = K_V;
                end else begin
                    byte_next = pcs.gmii_txd;
                    is_k_next = 1'b0;
                end
            end
            ST_EOP_T: begin
                state_next = ST_EOP_R;
                byte_next  = K_R;
            end
            ST_EOP_R: begin
                // A second /R/ pads to even alignment so the next /K28.5/ lands even.
                if (!next_even) begin
                    state_next = ST_EOP_R2;
                    byte_next  = K_R;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_EOP_R2: state_next = ST_IDLE;
            ST_CONFIG: begin
                if (cfg_pos_reg[1:0] == 2'b11) begin
                    pair_cnt_next = pair_cnt_done;
                    if (!xmit_config && pair_cnt_done >= MIN_PAIRS) begin
                        state_next = ST_IDLE;
                    end else begin
                        cfg_pos_next  = cfg_pos_inc;
                        cfg_word_next = config_tx;
                    end
                end else begin
                    cfg_pos_next = cfg_pos_inc;
                    is_k_next    = 1'b0;
                    case (cfg_pos_inc[1:0])
                        2'b01:   byte_next = cfg_pos_inc[2] ? D2_2 : D21_5;
                        2'b10:   byte_next = cfg_word_reg[7:0];
                        default: byte_next = cfg_word_reg[15:8];
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pcs.tx_byte     = byte_reg;
    assign pcs.tx_is_k     = is_k_reg;
    assign pcs.tx_even     = even_reg;
    assign pcs.tx_in_frame = in_frame_reg;
endmodule

// File: tb/tb_sgmii_pcs_tx.sv
// Bench for sgmii_pcs_tx: directed and random frames/config bursts against a stream-level model,
// with a second instance built without /V/ substitution to check raw error bytes.
module tb_sgmii_pcs_tx;
    localparam int MIN_SETS = 1;
    localparam logic [7:0] BC = 8'hBC, C5 = 8'hC5, I2 = 8'h50, B5 = 8'hB5, C2 = 8'h42;
    localparam logic [7:0] SK = 8'hFB, TK = 8'hFD, RK = 8'hF7, VK = 8'hFE;

    logic        clk_125mhz = 1'b0;
    logic        rst_n      = 1'b0;
    logic [7:0]  txd        = 8'h00;
    logic        tx_en      = 1'b0;
    logic        tx_err     = 1'b0;
    logic        disp       = 1'b0;
    logic        xc         = 1'b0;
    logic [15:0] cw         = 16'h0000;
    int          checks     = 0;
    int          errors     = 0;
    int          slot       = 0;

    always #4 clk_125mhz = ~clk_125mhz;

    sgmii_pcs_tx_if bus_v();
    sgmii_pcs_tx_if bus_r();
    assign bus_v.gmii_txd = txd;  assign bus_v.gmii_tx_en = tx_en;
    assign bus_v.gmii_tx_err = tx_err;  assign bus_v.tx_disp = disp;
    assign bus_r.gmii_txd = txd;  assign bus_r.gmii_tx_en = tx_en;
    assign bus_r.gmii_tx_err = tx_err;  assign bus_r.tx_disp = disp;

    sgmii_pcs_tx #(.VOID_ON_ERR(1'b1), .CFG_MIN_SETS(MIN_SETS)) dut_void (
        .clk_125mhz(clk_125mhz), .rst_n(rst_n), .pcs(bus_v),
        .xmit_config(xc), .config_tx(cw)
    );
    sgmii_pcs_tx #(.VOID_ON_ERR(1'b0), .CFG_MIN_SETS(MIN_SETS)) dut_raw (
        .clk_125mhz(clk_125mhz), .rst_n(rst_n), .pcs(bus_r),
        .xmit_config(xc), .config_tx(cw)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s slot=%0d observed=%h expected=%h", tag, slot, obs, expv);
        end
    endtask

    function automatic logic next_even();
        return ((slot + 1) % 2) == 0;
    endfunction

    task automatic chk_reset();
        chk("rst_byte", bus_v.tx_byte, BC);
        chk("rst_is_k", bus_v.tx_is_k, 1'b1);
        chk("rst_even", bus_v.tx_even, 1'b1);
        chk("rst_in_frame", bus_v.tx_in_frame, 1'b0);
        chk("rst_raw_byte", bus_r.tx_byte, BC);
    endtask

    task automatic run_cycle(input logic en, input logic [7:0] d, input logic er, input logic dp,
                             input logic x, input logic [15:0] w,
                             input logic [7:0] eb, input logic ek, input logic ef,
                             input logic [7:0] rb, input logic rk);
        tx_en = en; txd = d; tx_err = er; disp = dp; xc = x; cw = w;
        @(posedge clk_125mhz);
        #1;
        slot++;
        chk("byte", bus_v.tx_byte, eb);
        chk("is_k", bus_v.tx_is_k, ek);
        chk("even", bus_v.tx_even, (slot % 2) == 0);
        chk("in_frame", bus_v.tx_in_frame, ef);
        chk("raw_byte", bus_r.tx_byte, rb);
        chk("raw_is_k", bus_r.tx_is_k, rk);
        chk("raw_in_frame", bus_r.tx_in_frame, ef);
    endtask

    task automatic idle_cycle(input logic dp, input logic x);
        logic [7:0] b;
        logic       k;
        if (next_even()) begin
            b = BC; k = 1'b1;
        end else begin
            b = dp ? C5 : I2; k = 1'b0;
        end
        run_cycle(1'b0, 8'h00, 1'b0, dp, x, 16'($urandom), b, k, 1'b0, b, k);
    endtask

    // Frame of n GMII bytes; err_idx forces one errored byte, rand_err sprinkles more.
    task automatic send_frame(input int n, input int err_idx, input bit rand_err);
        logic [7:0] data [$];
        logic       err  [$];
        logic [7:0] eb [$];
        logic [7:0] rb [$];
        logic       ek [$];
        logic       rk [$];
        logic       ef [$];
        logic       dp0;
        bit         odd_start;
        int         first_data;
        int         nerr;
        odd_start  = !next_even();
        dp0        = 1'($urandom);
        first_data = odd_start ? 2 : 1;
        nerr       = 0;
        for (int i = 0; i < n; i++) begin
            data.push_back(8'($urandom));
            err.push_back((i == err_idx) ||
                          (rand_err && i >= first_data && $urandom_range(0, 5) == 0));
        end
        for (int i = 0; i < n; i++) begin
            if (i < first_data - 1) begin
                eb.push_back(dp0 ? C5 : I2); ek.push_back(1'b0); ef.push_back(1'b0);
                rb.push_back(dp0 ? C5 : I2); rk.push_back(1'b0);
            end else if (i == first_data - 1) begin
                eb.push_back(SK); ek.push_back(1'b1); ef.push_back(1'b1);
                rb.push_back(SK); rk.push_back(1'b1);
            end else begin
                if (err[i]) nerr++;
                eb.push_back(err[i] ? VK : data[i]); ek.push_back(err[i]); ef.push_back(1'b1);
                rb.push_back(data[i]); rk.push_back(1'b0);
            end
        end
        $display("frame len=%0d odd_start=%0d voided=%0d slot=%0d", n, odd_start, nerr, slot);
        for (int i = 0; i < n; i++)
            run_cycle(1'b1, data[i], err[i], (i == 0) ? dp0 : 1'($urandom), 1'b0, 16'($urandom),
                      eb[i], ek[i], ef[i], rb[i], rk[i]);
        run_cycle(1'b0, 8'h00, 1'b0, 1'($urandom), 1'b0, 16'h0, TK, 1'b1, 1'b1, TK, 1'b1);
        // tx_en re-asserted during /R/ must not disturb the end of packet
        run_cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 16'h0,
                  RK, 1'b1, 1'b0, RK, 1'b1);
        if (!next_even())
            run_cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 16'h0,
                      RK, 1'b1, 1'b0, RK, 1'b1);
        run_cycle(1'b0, 8'h00, 1'b0, 1'($urandom), 1'b0, 16'h0, BC, 1'b1, 1'b0, BC, 1'b1);
    endtask

    // xmit_config held for `hold` cycles from the entry /K28.5/; fixed selects a constant word.
    task automatic send_config(input int hold, input bit fixed, input logic [15:0] fw);
        int          sets;
        logic [15:0] word;
        logic [15:0] w;
        logic [7:0]  b;
        logic        k;
        if (!next_even()) idle_cycle(1'($urandom), 1'b1);
        sets = 1;
        while (!((4 * sets >= hold) && (sets / 2 >= MIN_SETS))) sets++;
        $display("config hold=%0d sets=%0d slot=%0d", hold, sets, slot);
        word = 16'h0;
        for (int c = 0; c < 4 * sets; c++) begin
            w = fixed ? fw : 16'($urandom);
            if (c % 4 == 0) word = w;
            case (c % 4)
                0:       begin b = BC; k = 1'b1; end
                1:       begin b = ((c / 4) % 2 == 0) ? B5 : C2; k = 1'b0; end
                2:       begin b = word[7:0]; k = 1'b0; end
                default: begin b = word[15:8]; k = 1'b0; end
            endcase
            run_cycle((c == 0) ? 1'b0 : 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                      (c < hold), w, b, k, 1'b0, b, k);
        end
        run_cycle(1'b0, 8'h00, 1'b0, 1'($urandom), 1'b0, 16'($urandom), BC, 1'b1, 1'b0, BC, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog slot=%0d", slot);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_125mhz);
        #1;
        chk_reset();
        rst_n = 1'b1;
        slot  = 0;
        $display("reset released");

        // Idle after reset: /I2/ pairs with even/odd alternation
        for (int i = 0; i < 6; i++) idle_cycle(1'b0, 1'b0);
        $display("idle run slot=%0d", slot);

        if (!next_even()) idle_cycle(1'b0, 1'b0);
        send_frame(8, -1, 1'b0);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        send_frame(8, -1, 1'b0);
        if (!next_even()) idle_cycle(1'b0, 1'b0);
        send_frame(8, 4, 1'b0);

        send_config(2, 1'b1, 16'h4001);
        send_config(9, 1'b0, 16'h0000);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    int gap;
                    gap = $urandom_range(0, 4);
                    $display("idle gap=%0d slot=%0d", gap, slot);
                    for (int i = 0; i < gap; i++) idle_cycle(1'($urandom), 1'b0);
                end
                1, 2: send_frame($urandom_range(8, 20), -1, 1'b1);
                default: send_config($urandom_range(1, 14), 1'b0, 16'h0000);
            endcase
        end

        // Asynchronous reset in the middle of a frame
        if (!next_even()) idle_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0, SK, 1'b1, 1'b1, SK, 1'b1);
        run_cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 16'h0, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b0);
        run_cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 16'h0, 8'hA2, 1'b0, 1'b1, 8'hA2, 1'b0);
        #2;
        rst_n = 1'b0;
        tx_en = 1'b0;
        #1;
        $display("async reset mid-frame slot=%0d", slot);
        chk_reset();
        @(posedge clk_125mhz);
        #1;
        chk_reset();
        rst_n = 1'b1;
        slot  = 0;
        for (int i = 0; i < 4; i++) idle_cycle(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
